// File: rtl/guess_pkg.sv
// guess_pkg: shared types and default sizes for the guess-number sequencer.
//   phase_t : FSM state encoding, also exported on the phase port
//   sym_t   : 2-bit key symbol, SYM_I1..SYM_I4 = 0..3
//   *_DEF   : default MAX_LEN, MIN_LEN and MAX_TURNS
package guess_pkg;
    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        COMPARE = 3'd2,
        RESULT  = 3'd3,
        WIN     = 3'd4,
        LOSE    = 3'd5
    } phase_t;
    typedef logic [1:0] sym_t;
    localparam sym_t SYM_I1 = 2'd0;
    localparam sym_t SYM_I2 = 2'd1;
    localparam sym_t SYM_I3 = 2'd2;
    localparam sym_t SYM_I4 = 2'd3;
    localparam int MAX_LEN_DEF   = 7;
    localparam int MIN_LEN_DEF   = 4;
    localparam int MAX_TURNS_DEF = 3;
endpackage

// File: rtl/guess_key_frontend.sv
// guess_key_frontend: synchronizes raw keys, detects rising edges, priority-encodes symbols.
//   clk, reset      : clock, synchronous active-low reset
//   I1..I4, enter   : raw asynchronous keys
//   key_valid       : one-cycle pulse when any symbol key rose
//   key_sym         : symbol of the lowest-index key that rose
//   enter_pulse     : one-cycle enter pulse, suppressed when a symbol key rose together
module guess_key_frontend
    import guess_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic I1,
    input  logic I2,
    input  logic I3,
    input  logic I4,
    input  logic enter,
    output logic key_valid,
    output sym_t key_sym,
    output logic enter_pulse
);
    logic [4:0] raw, s1, s2, s3, rise;

    assign raw = {enter, I4, I3, I2, I1};

    // s1/s2 form the synchronizer, s3 holds the previous synchronized level
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise        = s2 & ~s3;
    assign key_valid   = |rise[3:0];
    assign key_sym     = rise[0] ? SYM_I1 : rise[1] ? SYM_I2 : rise[2] ? SYM_I3 : SYM_I4;
    assign enter_pulse = rise[4] & ~key_valid;
endmodule

// File: rtl/guess_game_seq.sv
// guess_game_seq: secret/guess entry, serial compare and win/lose sequencing.
//   clk, reset            : clock, synchronous active-low reset
//   I1..I4, enter         : raw asynchronous keys
//   phase                 : current FSM state (guess_pkg::phase_t encoding)
//   secret_o, guess_o     : symbol buffers, slot i at bits [2i+1:2i]
//   numa, numb            : secret and guess lengths
//   turn                  : failed-guess count
//   win, lose             : sticky game outcome
//   equal, bigger, smaller: length relation from the last compare
module guess_game_seq
    import guess_pkg::*;
#(
    parameter int MAX_LEN   = MAX_LEN_DEF,
    parameter int MIN_LEN   = MIN_LEN_DEF,
    parameter int MAX_TURNS = MAX_TURNS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 I1,
    input  logic                 I2,
    input  logic                 I3,
    input  logic                 I4,
    input  logic                 enter,
    output logic [2:0]           phase,
    output logic [2*MAX_LEN-1:0] secret_o,
    output logic [2*MAX_LEN-1:0] guess_o,
    output logic [3:0]           numa,
    output logic [3:0]           numb,
    output logic [1:0]           turn,
    output logic                 win,
    output logic                 lose,
    output logic                 equal,
    output logic                 bigger,
    output logic                 smaller
);
    localparam int IW = $clog2(MAX_LEN);
    localparam logic [3:0]    LMAX  = 4'(MAX_LEN);
    localparam logic [3:0]    LMIN  = 4'(MIN_LEN);
    localparam logic [1:0]    TMAX  = 2'(MAX_TURNS);
    localparam logic [IW-1:0] ILAST = IW'(MAX_LEN - 1);

    phase_t                  st;
    logic [MAX_LEN-1:0][1:0] secret, guess;
    logic [IW-1:0]           idx;
    logic                    mism;
    logic                    key_valid, enter_pulse;
    sym_t                    key_sym;

    guess_key_frontend u_fe (
        .clk        (clk),
        .reset      (reset),
        .I1         (I1),
        .I2         (I2),
        .I3         (I3),
        .I4         (I4),
        .enter      (enter),
        .key_valid  (key_valid),
        .key_sym    (key_sym),
        .enter_pulse(enter_pulse)
    );

    assign phase    = st;
    assign secret_o = secret;
    assign guess_o  = guess;

    always_ff @(posedge clk) begin
        if (!reset) begin
            st      <= ENTER_A;
            secret  <= '0;
            guess   <= '0;
            numa    <= '0;
            numb    <= '0;
            turn    <= '0;
            win     <= 1'b0;
            lose    <= 1'b0;
            equal   <= 1'b0;
            bigger  <= 1'b0;
            smaller <= 1'b0;
            idx     <= '0;
            mism    <= 1'b0;
        end else begin
            case (st)
                ENTER_A: begin
                    // a full secret hands over to player B without waiting for enter
                    if (key_valid) begin
                        secret[numa[IW-1:0]] <= key_sym;
                        numa <= numa + 4'd1;
                        if (numa + 4'd1 == LMAX) st <= ENTER_B;
                    end else if (enter_pulse && numa >= LMIN) begin
                        st <= ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (key_valid) begin
                        if (numb < LMAX) begin
                            guess[numb[IW-1:0]] <= key_sym;
                            numb <= numb + 4'd1;
                        end
                    end else if (enter_pulse && numb >= LMIN) begin
                        st   <= COMPARE;
                        idx  <= '0;
                        mism <= 1'b0;
                    end
                end
                COMPARE: begin
                    // unused slots are zero in both buffers, so scanning every slot is safe
                    if (secret[idx] != guess[idx]) mism <= 1'b1;
                    idx <= idx + 1'b1;
                    if (idx == ILAST) st <= RESULT;
                end
                RESULT: begin
                    equal   <= numa == numb;
                    bigger  <= numa > numb;
                    smaller <= numa < numb;
                    if (numa == numb && !mism) begin
                        win <= 1'b1;
                        st  <= WIN;
                    end else begin
                        turn <= turn + 2'd1;
                        if (turn + 2'd1 == TMAX) begin
                            lose <= 1'b1;
                            st   <= LOSE;
                        end else begin
                            guess <= '0;
                            numb  <= '0;
                            st    <= ENTER_B;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_guess_game_seq.sv
// tb_guess_game_seq: scoreboard bench with a queue-based game model and random games.
module tb_guess_game_seq;
    localparam int ML = 7;
    localparam int MN = 4;
    localparam int MT = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [3:0]      keys = 4'b0;
    logic            enter = 1'b0;
    logic [2:0]      phase;
    logic [2*ML-1:0] secret_o, guess_o;
    logic [3:0]      numa, numb;
    logic [1:0]      turn;
    logic            win, lose, equal, bigger, smaller;

    guess_game_seq dut (
        .clk     (clk),
        .reset   (reset),
        .I1      (keys[0]),
        .I2      (keys[1]),
        .I3      (keys[2]),
        .I4      (keys[3]),
        .enter   (enter),
        .phase   (phase),
        .secret_o(secret_o),
        .guess_o (guess_o),
        .numa    (numa),
        .numb    (numb),
        .turn    (turn),
        .win     (win),
        .lose    (lose),
        .equal   (equal),
        .bigger  (bigger),
        .smaller (smaller)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w, l, t, eq, bg, sm, nb, ph;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] sec_q[$];
    logic [1:0] gue_q[$];
    int         mode;
    int         m_turn, m_eq, m_bg, m_sm;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pack(input logic [1:0] q[$]);
        int v = 0;
        foreach (q[i]) v |= int'(q[i]) << (2 * i);
        return v;
    endfunction

    function automatic int model_phase();
        return mode == 0 ? 0 : mode == 1 ? 1 : mode == 2 ? 4 : 5;
    endfunction

    function automatic void model_clear();
        sec_q.delete();
        gue_q.delete();
        sb.delete();
        mode = 0;
        m_turn = 0;
        m_eq = 0;
        m_bg = 0;
        m_sm = 0;
    endfunction

    // game rules at the level of symbol lists; returns 1 when a guess was submitted
    function automatic bit model_step(input logic [3:0] m, input bit en);
        logic [1:0] s;
        bit match;
        exp_t e;
        if (mode >= 2) return 0;
        if (m != 0) begin
            s = m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
            if (mode == 0) begin
                sec_q.push_back(s);
                if (sec_q.size() == ML) mode = 1;
            end else if (gue_q.size() < ML) begin
                gue_q.push_back(s);
            end
            return 0;
        end
        if (!en) return 0;
        if (mode == 0) begin
            if (sec_q.size() >= MN) mode = 1;
            return 0;
        end
        if (gue_q.size() < MN) return 0;
        match = sec_q.size() == gue_q.size();
        foreach (gue_q[i]) if (match && gue_q[i] != sec_q[i]) match = 0;
        m_eq = int'(sec_q.size() == gue_q.size());
        m_bg = int'(sec_q.size() > gue_q.size());
        m_sm = int'(sec_q.size() < gue_q.size());
        if (match) mode = 2;
        else begin
            m_turn++;
            if (m_turn == MT) mode = 3;
            else gue_q.delete();
        end
        e.w = int'(mode == 2);
        e.l = int'(mode == 3);
        e.t = m_turn;
        e.eq = m_eq;
        e.bg = m_bg;
        e.sm = m_sm;
        e.nb = gue_q.size();
        e.ph = model_phase();
        sb.push_back(e);
        return 1;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".phase"}, int'(phase), model_phase());
        chk({tag, ".numa"}, int'(numa), sec_q.size());
        chk({tag, ".numb"}, int'(numb), gue_q.size());
        chk({tag, ".secret"}, int'(secret_o), pack(sec_q));
        chk({tag, ".guess"}, int'(guess_o), pack(gue_q));
        chk({tag, ".turn"}, int'(turn), m_turn);
        chk({tag, ".winlose"}, int'({win, lose}), (mode == 2 ? 2 : 0) + (mode == 3 ? 1 : 0));
        chk({tag, ".flags"}, int'({equal, bigger, smaller}), m_eq * 4 + m_bg * 2 + m_sm);
    endtask

    // raw rise at a negedge; the third posedge afterwards commits it
    task automatic press(input logic [3:0] m, input bit en, output bit cmp);
        @(negedge clk);
        keys = m;
        enter = en;
        @(negedge clk);
        keys = 4'b0;
        enter = 1'b0;
        repeat (2) @(negedge clk);
        cmp = model_step(m, en);
    endtask

    task automatic wait_result();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("result_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic act(input logic [3:0] m, input bit en, input string tag);
        bit cmp;
        press(m, en, cmp);
        if (cmp) wait_result();
        check_state(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        keys = 4'b0;
        enter = 1'b0;
        @(negedge clk);
        model_clear();
        check_state("reset");
        reset = 1'b1;
    endtask

    // monitor: a RESULT cycle is the DUT's output event; compare one cycle later
    logic [2:0] prev_ph = 3'd0;
    always @(negedge clk) begin
        exp_t e;
        if (reset && prev_ph == 3'd3) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: phase %0d with no pending expectation", phase);
            end else begin
                e = sb.pop_front();
                chk("res.win", int'(win), e.w);
                chk("res.lose", int'(lose), e.l);
                chk("res.turn", int'(turn), e.t);
                chk("res.flags", int'({equal, bigger, smaller}), e.eq * 4 + e.bg * 2 + e.sm);
                chk("res.numb", int'(numb), e.nb);
                chk("res.phase", int'(phase), e.ph);
            end
        end
        prev_ph = phase;
    end

    initial begin
        bit cmp;
        model_clear();
        repeat (2) @(negedge clk);
        check_state("por");
        reset = 1'b1;

        // exact guess wins; check compare latency
        foreach (keys[i]) act(4'(1 << i), 0, "t1_sec");
        act(0, 1, "t1_sec_ent");
        foreach (keys[i]) act(4'(1 << i), 0, "t1_gue");
        press(0, 1, cmp);
        repeat (7) @(negedge clk);
        chk("t1_lat_result", int'(phase), 3);
        @(negedge clk);
        chk("t1_lat_win", int'(phase), 4);
        wait_result();
        check_state("t1_end");

        // enter below MIN_LEN ignored
        do_reset();
        act(4'b0001, 0, "t2");
        act(4'b0010, 0, "t2");
        act(4'b0100, 0, "t2");
        act(0, 1, "t2_short_ent");
        act(4'b1000, 0, "t2");
        act(0, 1, "t2_ent");

        // seven keys auto-advance, eighth goes to guess
        do_reset();
        for (int i = 0; i < ML; i++) act(4'(1 << $urandom_range(0, 3)), 0, "t3_sec");
        act(4'b0010, 0, "t3_gue0");

        // three wrong over-long guesses lose
        do_reset();
        for (int i = 0; i < MN; i++) act(4'b0001, 0, "t4_sec");
        act(0, 1, "t4_ent");
        for (int g = 0; g < MT; g++) begin
            for (int i = 0; i < 5; i++) act(4'b0001, 0, "t4_gue");
            act(0, 1, "t4_res");
        end
        act(4'b0100, 0, "t4_ignored");
        act(0, 1, "t4_ignored_ent");

        // simultaneous keys and key-with-enter
        do_reset();
        act(4'b0101, 0, "t5_prio");
        act(4'b1110, 0, "t5_prio2");
        act(4'b1000, 0, "t5");
        act(4'b0001, 0, "t5");
        act(4'b0010, 1, "t5_key_ent");

        // reset in the third COMPARE cycle
        do_reset();
        for (int i = 0; i < MN; i++) act(4'b0100, 0, "t6_sec");
        act(0, 1, "t6_ent");
        for (int i = 0; i < MN; i++) act(4'b0100, 0, "t6_gue");
        press(0, 1, cmp);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_clear();
        check_state("t6_midreset");
        reset = 1'b1;

        // random games
        for (int g = 0; g < 8; g++) begin
            if (g != 0) do_reset();
            for (int s = 0; s < 80 && mode < 2; s++) begin
                int r;
                r = $urandom_range(0, 9);
                if (mode == 1 && gue_q.size() == 0 && $urandom_range(0, 2) == 0) begin
                    logic [1:0] cp[$];
                    cp = sec_q;
                    foreach (cp[i]) act(4'(1 << cp[i]), 0, "rnd_copy");
                    act(0, 1, "rnd_copy_ent");
                end else if (r < 7) act(4'(1 << $urandom_range(0, 3)), 0, "rnd_key");
                else if (r == 7) act(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), "rnd_multi");
                else act(0, 1, "rnd_ent");
            end
            act(4'b0001, 0, "rnd_tail");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
